fetch_dispatch: RTL and testbench
=================================

// Module: fetch_dispatch
// PURPOSE
//   Fetch-instruction dispatcher. Sits between the instruction queue and the feature/weight fetch units.
//   Accepts one 64-bit fetch instruction at a time and decodes it. Drives the fetch unit's field bus
//   and issues a 1-cycle enable, then waits for completion before accepting the next instruction.
//   Reports completion, sticky errors and a retired-instruction count to the top FSM.
// PARAMETERS
//   TIMEOUT_CYCLES  1024  max WAIT cycles before abort (>=2)
//   SCALER_WAIT     3     fixed completion delay for scaler fetch, in cycles (>=1); scaler path has no done
// PORTS
//   clk                    in   1   clock, rising edge
//   rst                    in   1   reset, asynchronous, active-low (0 = reset)
//   instr_valid            in   1   instruction present
//   instr_ready            out  1   dispatcher can accept
//   instr                  in   64  [63:56]op [55:48]f_type [47:32]src_addr [31:16]dst [15:8]mem_sel [7:0]counter
//   feature_fetch_enable   out  1   1-cycle pulse to feature fetch
//   weight_fetch_enable    out  1   1-cycle pulse to weight fetch
//   scaler_fetch_enable    out  1   1-cycle pulse to weight fetch (scaler buffer)
//   fetch_type             out  8   decoded f_type
//   src_addr               out  16  source address
//   dst_addr               out  8   destination address = instr[23:16] (dst low byte)
//   mem_sel                out  8   feature buffer select
//   fetch_counter          out  8   burst length, passed through unmodified
//   feature_fetch_done     in   1   completion pulse from feature fetch
//   weight_fetch_done      in   1   completion pulse from weight fetch
//   cmd_done               out  1   1-cycle pulse, instruction retired
//   busy                   out  1   high in any state except IDLE
//   err_illegal            out  1   sticky: unknown opcode seen
//   err_timeout            out  1   sticky: WAIT exceeded TIMEOUT_CYCLES
//   err_clr                in   1   clears both sticky errors
//   instr_count            out  16  retired instructions, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset: all outputs 0, except instr_ready=1. State=IDLE.
//     Reset mid-WAIT aborts the instruction; no cmd_done is issued.
//   Opcodes: 0x00 NOP, 0x01 FEATURE, 0x02 WEIGHT, 0x03 SCALER; anything else is illegal.
//   instr_ready = (state==IDLE). Handshake = instr_valid & instr_ready.
//     On handshake, register all field outputs.
//     Field outputs hold until the next handshake.
//   States:
//     IDLE  -> ISSUE   on handshake with op 0x01/0x02/0x03.
//           NOP: stays IDLE; cmd_done and count increment next cycle.
//           Illegal: stays IDLE; err_illegal set, cmd_done and count increment next cycle.
//     ISSUE (1 cycle) -> WAIT
//           Assert the matching *_enable; fields are already stable.
//           Clear the wait counter.
//     WAIT  -> IDLE    on completion or timeout.
//           Completion sources: FEATURE=feature_fetch_done, WEIGHT=weight_fetch_done,
//           SCALER=wait counter reaches SCALER_WAIT-1.
//           Timeout: wait counter reaches TIMEOUT_CYCLES-1 without completion.
//             Sets err_timeout; cmd_done still pulses and count still increments.
//             Completion in the timeout cycle wins; err_timeout is not set.
//   cmd_done pulses in the cycle after WAIT exits, coincident with instr_ready returning to 1.
//   Latency (valid accept to enable) = 1 cycle.
//   Done inputs outside WAIT, and the wrong unit's done, are ignored.
//   err_clr in the same cycle as a new error: the set wins.
//   Enables are never asserted simultaneously; at most one instruction is in flight.
// TESTING
//   Reset, then FEATURE instr 0x01_00_0040_0005_01_04, done 6 cycles after enable.
//     -> feature_fetch_enable 1 cycle after accept; src=0x0040, dst=0x05, mem_sel=0x01, counter=4.
//     -> cmd_done 1 cycle after done; instr_count=1.
//   WEIGHT with weight_fetch_done 3 cycles after enable -> weight enable only; cmd_done; busy low after.
//   SCALER -> scaler enable; cmd_done exactly SCALER_WAIT+1 cycles after enable; weight_fetch_done ignored.
//   Opcode 0x7F -> err_illegal=1, no enable, cmd_done next cycle; err_clr -> err_illegal=0.
//   FEATURE with no done, TIMEOUT_CYCLES=16 -> err_timeout=1 after 16 WAIT cycles; next instr accepted.
//   rst low in WAIT, instr_valid held high, then FEATURE issued -> outputs zero, no cmd_done.
//     -> after release, the held instruction is accepted on the first cycle.

Source files
------------

// File: rtl/fetch_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_dispatch_if
// Purpose  : Instruction handshake, fetch-unit field/enable bus, completion
//            and status signals of the fetch-instruction dispatcher.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_dispatch_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [63:0] instr;
  logic        feature_fetch_enable;
  logic        weight_fetch_enable;
  logic        scaler_fetch_enable;
  logic [7:0]  fetch_type;
  logic [15:0] src_addr;
  logic [7:0]  dst_addr;
  logic [7:0]  mem_sel;
  logic [7:0]  fetch_counter;
  logic        feature_fetch_done;
  logic        weight_fetch_done;
  logic        cmd_done;
  logic        busy;
  logic        err_illegal;
  logic        err_timeout;
  logic        err_clr;
  logic [15:0] instr_count;

  // Dispatcher side
  modport slave (
    input  instr_valid, instr, feature_fetch_done, weight_fetch_done, err_clr,
    output instr_ready, feature_fetch_enable, weight_fetch_enable,
           scaler_fetch_enable, fetch_type, src_addr, dst_addr, mem_sel,
           fetch_counter, cmd_done, busy, err_illegal, err_timeout, instr_count
  );

  // Instruction queue / fetch units / top FSM side
  modport master (
    output instr_valid, instr, feature_fetch_done, weight_fetch_done, err_clr,
    input  instr_ready, feature_fetch_enable, weight_fetch_enable,
           scaler_fetch_enable, fetch_type, src_addr, dst_addr, mem_sel,
           fetch_counter, cmd_done, busy, err_illegal, err_timeout, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : fetch_dispatch
// Purpose  : Decodes one 64-bit fetch instruction at a time, drives the fetch
//            field bus, pulses the matching fetch enable and waits for
//            completion (or timeout) before accepting the next instruction.
// Revision : 1.0  initial release
// ============================================================================
module fetch_dispatch #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SCALER_WAIT    = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,      // asynchronous, active-low
  fetch_dispatch_if.slave   bus
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;

  localparam logic [1:0] c_K_FEAT = 2'd0;
  localparam logic [1:0] c_K_WGT  = 2'd1;
  localparam logic [1:0] c_K_SCL  = 2'd2;

  localparam logic [7:0] c_OP_NOP     = 8'h00;
  localparam logic [7:0] c_OP_FEATURE = 8'h01;
  localparam logic [7:0] c_OP_WEIGHT  = 8'h02;
  localparam logic [7:0] c_OP_SCALER  = 8'h03;

  // Wait counter must reach both TIMEOUT_CYCLES-1 and SCALER_WAIT-1
  localparam int c_CNT_MAX = (TIMEOUT_CYCLES > SCALER_WAIT) ? TIMEOUT_CYCLES : SCALER_WAIT;
  localparam int c_CNT_W   = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_SC_LAST = c_CNT_W'(SCALER_WAIT - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [1:0]         r_kind;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic [7:0]         r_fetch_type;
  logic [15:0]        r_src_addr;
  logic [7:0]         r_dst_addr;
  logic [7:0]         r_mem_sel;
  logic [7:0]         r_fetch_counter;
  logic               r_cmd_done;
  logic               r_err_illegal;
  logic               r_err_timeout;
  logic [15:0]        r_instr_count;

  logic               w_ready;
  logic               w_busy;
  logic               w_feat_en;
  logic               w_wgt_en;
  logic               w_scl_en;
  logic               w_handshake;
  logic [7:0]         w_op;
  logic               w_op_fetch;
  logic               w_op_illegal;
  logic               w_complete;
  logic               w_cnt_last;
  logic               w_wait_exit;
  logic               w_timeout;
  logic               w_retire;
  logic               w_unused_dst_hi;

  assign w_op            = bus.instr[63:56];
  assign w_handshake     = bus.instr_valid & w_ready;
  assign w_op_fetch      = (w_op == c_OP_FEATURE) | (w_op == c_OP_WEIGHT) | (w_op == c_OP_SCALER);
  assign w_op_illegal    = ~w_op_fetch & (w_op != c_OP_NOP);
  // Only the low byte of the dst field reaches the fetch units
  assign w_unused_dst_hi = ^bus.instr[31:24];

  // Completion source depends on which unit the in-flight instruction targets
  always_comb begin
    w_complete = 1'b0;
    case (r_kind)
      c_K_FEAT: w_complete = bus.feature_fetch_done;
      c_K_WGT:  w_complete = bus.weight_fetch_done;
      c_K_SCL:  w_complete = (r_wait_cnt == c_SC_LAST);
      default:  w_complete = 1'b0;
    endcase
  end

  assign w_cnt_last  = (r_wait_cnt == c_TO_LAST);
  assign w_wait_exit = (r_state == c_ST_WAIT) & (w_complete | w_cnt_last);
  // Completion in the final cycle wins over timeout
  assign w_timeout   = (r_state == c_ST_WAIT) & w_cnt_last & ~w_complete;
  // NOP and illegal ops retire straight from IDLE
  assign w_retire    = (w_handshake & ~w_op_fetch) | w_wait_exit;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_handshake && w_op_fetch) w_state_nxt = c_ST_ISSUE;
      c_ST_ISSUE: w_state_nxt = c_ST_WAIT;
      c_ST_WAIT:  if (w_wait_exit) w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State-decoded outputs: handshake readiness, busy and one-cycle enables
  always_comb begin
    w_ready   = (r_state == c_ST_IDLE);
    w_busy    = (r_state != c_ST_IDLE);
    w_feat_en = (r_state == c_ST_ISSUE) & (r_kind == c_K_FEAT);
    w_wgt_en  = (r_state == c_ST_ISSUE) & (r_kind == c_K_WGT);
    w_scl_en  = (r_state == c_ST_ISSUE) & (r_kind == c_K_SCL);
  end

  // Capture decoded fields on every accepted instruction; held until the next
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kind          <= c_K_FEAT;
      r_fetch_type    <= '0;
      r_src_addr      <= '0;
      r_dst_addr      <= '0;
      r_mem_sel       <= '0;
      r_fetch_counter <= '0;
    end else if (w_handshake) begin
      r_kind          <= (w_op == c_OP_WEIGHT) ? c_K_WGT :
                         (w_op == c_OP_SCALER) ? c_K_SCL : c_K_FEAT;
      r_fetch_type    <= bus.instr[55:48];
      r_src_addr      <= bus.instr[47:32];
      r_dst_addr      <= bus.instr[23:16];
      r_mem_sel       <= bus.instr[15:8];
      r_fetch_counter <= bus.instr[7:0];
    end
  end

  // Wait counter: cleared while issuing, counts WAIT cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_wait_cnt <= '0;
    else if (r_state == c_ST_ISSUE)   r_wait_cnt <= '0;
    else if (r_state == c_ST_WAIT)    r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  // Retire pulse, retired count and sticky errors (a new error beats err_clr)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_done    <= 1'b0;
      r_instr_count <= '0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_cmd_done <= w_retire;
      if (w_retire) r_instr_count <= r_instr_count + 16'd1;
      if (w_handshake && w_op_illegal) r_err_illegal <= 1'b1;
      else if (bus.err_clr)            r_err_illegal <= 1'b0;
      if (w_timeout)                   r_err_timeout <= 1'b1;
      else if (bus.err_clr)            r_err_timeout <= 1'b0;
    end
  end

  assign bus.instr_ready          = w_ready;
  assign bus.busy                 = w_busy;
  assign bus.feature_fetch_enable = w_feat_en;
  assign bus.weight_fetch_enable  = w_wgt_en;
  assign bus.scaler_fetch_enable  = w_scl_en;
  assign bus.fetch_type           = r_fetch_type;
  assign bus.src_addr             = r_src_addr;
  assign bus.dst_addr             = r_dst_addr;
  assign bus.mem_sel              = r_mem_sel;
  assign bus.fetch_counter        = r_fetch_counter;
  assign bus.cmd_done             = r_cmd_done;
  assign bus.err_illegal          = r_err_illegal;
  assign bus.err_timeout          = r_err_timeout;
  assign bus.instr_count          = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_dispatch
// Purpose  : Self-checking bench for fetch_dispatch; directed scenarios plus
//            randomized instruction streams against a cycle-offset model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_dispatch;
  localparam int TO = 16;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference state: retired count and sticky error flags
  logic [15:0] m_count = '0;
  bit          m_ill   = 1'b0;
  bit          m_to    = 1'b0;

  fetch_dispatch_if ifc ();

  fetch_dispatch #(.TIMEOUT_CYCLES(TO), .SCALER_WAIT(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ifc.instr_valid        = 1'b0;
    ifc.instr              = '0;
    ifc.feature_fetch_done = 1'b0;
    ifc.weight_fetch_done  = 1'b0;
    ifc.err_clr            = 1'b0;
  endtask

  function automatic logic [63:0] mk_instr(input logic [7:0] op);
    return {op, 8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom)};
  endfunction

  // Issue one instruction; d = cycle after enable on which the right done pulses (0 = never)
  task automatic run_instr(input logic [63:0] ins, input int d, input bit clr);
    logic [7:0] op;
    bit         is_fetch;
    bit         is_ill;
    int         exp_t;
    bit         exp_to;
    logic [2:0] exp_en;
    logic [2:0] got_en;
    op       = ins[63:56];
    is_fetch = (op >= 8'h01) && (op <= 8'h03);
    is_ill   = (op > 8'h03);

    n_cmp++; if (ifc.instr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_before_accept: got %b want 1", ifc.instr_ready); end
    ifc.instr       = ins;
    ifc.instr_valid = 1'b1;
    ifc.err_clr     = clr;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    ifc.err_clr     = 1'b0;
    ifc.instr       = mk_instr(8'($urandom));
    m_ill = is_ill | (m_ill & ~clr);
    m_to  = m_to & ~clr;
    got_en = {ifc.feature_fetch_enable, ifc.weight_fetch_enable, ifc.scaler_fetch_enable};

    if (!is_fetch) begin
      m_count = m_count + 16'd1;
      n_cmp++; if (got_en !== 3'b000) begin n_fail++; $display("FAIL nop_ill_enables: got %b want 000", got_en); end
      n_cmp++; if (ifc.cmd_done !== 1'b1) begin n_fail++; $display("FAIL nop_ill_cmd_done: got %b want 1", ifc.cmd_done); end
      n_cmp++; if (ifc.instr_count !== m_count) begin n_fail++; $display("FAIL nop_ill_count: got %h want %h", ifc.instr_count, m_count); end
      n_cmp++; if ({ifc.err_illegal, ifc.err_timeout} !== {m_ill, m_to}) begin n_fail++; $display("FAIL nop_ill_errs: got %b%b want %b%b", ifc.err_illegal, ifc.err_timeout, m_ill, m_to); end
      n_cmp++; if ({ifc.instr_ready, ifc.busy} !== 2'b10) begin n_fail++; $display("FAIL nop_ill_ready_busy: got %b%b want 10", ifc.instr_ready, ifc.busy); end
      return;
    end

    exp_en = (op == 8'h01) ? 3'b100 : (op == 8'h02) ? 3'b010 : 3'b001;
    if (op == 8'h03) begin exp_t = SW + 1; exp_to = 1'b0; end
    else if (d >= 1 && d <= TO) begin exp_t = d + 1; exp_to = 1'b0; end
    else begin exp_t = TO + 1; exp_to = 1'b1; end

    n_cmp++; if (got_en !== exp_en) begin n_fail++; $display("FAIL enable_onehot: got %b want %b", got_en, exp_en); end
    n_cmp++; if ({ifc.fetch_type, ifc.src_addr, ifc.dst_addr, ifc.mem_sel, ifc.fetch_counter} !== {ins[55:32], ins[23:0]}) begin
      n_fail++; $display("FAIL fields_at_enable: got %h want %h", {ifc.fetch_type, ifc.src_addr, ifc.dst_addr, ifc.mem_sel, ifc.fetch_counter}, {ins[55:32], ins[23:0]}); end
    n_cmp++; if ({ifc.cmd_done, ifc.busy, ifc.instr_ready} !== 3'b010) begin n_fail++; $display("FAIL issue_status: got %b%b%b want 010", ifc.cmd_done, ifc.busy, ifc.instr_ready); end

    // Dones during the issue cycle must be ignored
    ifc.feature_fetch_done = 1'($urandom);
    ifc.weight_fetch_done  = 1'($urandom);
    for (int t = 1; t <= exp_t; t++) begin
      @(posedge clk); #1;
      got_en = {ifc.feature_fetch_enable, ifc.weight_fetch_enable, ifc.scaler_fetch_enable};
      if (t < exp_t) begin
        n_cmp++; if ({ifc.cmd_done, ifc.busy, got_en} !== 5'b01000) begin n_fail++; $display("FAIL wait_status t=%0d: got %b%b%b want 01000", t, ifc.cmd_done, ifc.busy, got_en); end
        // Right unit's done only at cycle d; the other unit's done is noise
        ifc.feature_fetch_done = (op == 8'h01) ? (t == d) : 1'($urandom);
        ifc.weight_fetch_done  = (op == 8'h02) ? (t == d) : 1'($urandom);
      end else begin
        ifc.feature_fetch_done = 1'b0;
        ifc.weight_fetch_done  = 1'b0;
        m_count = m_count + 16'd1;
        m_to    = m_to | exp_to;
        n_cmp++; if ({ifc.cmd_done, ifc.busy, ifc.instr_ready} !== 3'b101) begin n_fail++; $display("FAIL retire_status: got %b%b%b want 101", ifc.cmd_done, ifc.busy, ifc.instr_ready); end
        n_cmp++; if (ifc.instr_count !== m_count) begin n_fail++; $display("FAIL retire_count: got %h want %h", ifc.instr_count, m_count); end
        n_cmp++; if ({ifc.err_illegal, ifc.err_timeout} !== {m_ill, m_to}) begin n_fail++; $display("FAIL retire_errs: got %b%b want %b%b", ifc.err_illegal, ifc.err_timeout, m_ill, m_to); end
        n_cmp++; if ({ifc.src_addr, ifc.dst_addr} !== {ins[47:32], ins[23:16]}) begin n_fail++; $display("FAIL fields_hold: got %h want %h", {ifc.src_addr, ifc.dst_addr}, {ins[47:32], ins[23:16]}); end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ifc.instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ifc.instr_ready); end
    n_cmp++; if ({ifc.feature_fetch_enable, ifc.weight_fetch_enable, ifc.scaler_fetch_enable, ifc.cmd_done, ifc.busy, ifc.err_illegal, ifc.err_timeout} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {ifc.feature_fetch_enable, ifc.weight_fetch_enable, ifc.scaler_fetch_enable, ifc.cmd_done, ifc.busy, ifc.err_illegal, ifc.err_timeout}); end
    n_cmp++; if ({ifc.fetch_type, ifc.src_addr, ifc.dst_addr, ifc.mem_sel, ifc.fetch_counter, ifc.instr_count} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {ifc.fetch_type, ifc.src_addr, ifc.dst_addr, ifc.mem_sel, ifc.fetch_counter, ifc.instr_count}); end
    rst     = 1'b1;
    m_count = '0;
    m_ill   = 1'b0;
    m_to    = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_feature();
    run_instr(64'h01_00_0040_0005_01_04, 6, 1'b0);
    n_cmp++; if ({ifc.src_addr, ifc.dst_addr, ifc.mem_sel, ifc.fetch_counter} !== 40'h0040_05_01_04) begin
      n_fail++; $display("FAIL feature_fields: got %h want 0040050104", {ifc.src_addr, ifc.dst_addr, ifc.mem_sel, ifc.fetch_counter}); end
    n_cmp++; if (ifc.instr_count !== 16'd1) begin n_fail++; $display("FAIL feature_count: got %0d want 1", ifc.instr_count); end
  endtask

  task automatic test_weight();
    run_instr(mk_instr(8'h02), 3, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if ({ifc.busy, ifc.cmd_done} !== 2'b00) begin n_fail++; $display("FAIL weight_after: got %b%b want 00", ifc.busy, ifc.cmd_done); end
  endtask

  task automatic test_scaler();
    run_instr(mk_instr(8'h03), 0, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr(mk_instr(8'h7F), 0, 1'b0);
    ifc.err_clr = 1'b1;
    @(posedge clk); #1;
    ifc.err_clr = 1'b0;
    m_ill = 1'b0;
    m_to  = 1'b0;
    n_cmp++; if (ifc.err_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clear: got %b want 0", ifc.err_illegal); end
    // Setting wins over a coincident clear
    run_instr(mk_instr(8'hC4), 0, 1'b1);
  endtask

  task automatic test_timeout();
    run_instr(mk_instr(8'h01), 0, 1'b0);
    // Done landing in the final wait cycle completes normally
    run_instr(mk_instr(8'h02), TO, 1'b0);
    run_instr(mk_instr(8'h00), 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] op;
    int         sel;
    int         d;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      op  = (sel == 0) ? 8'h00 : (sel <= 3) ? 8'h01 : (sel <= 5) ? 8'h02 :
            (sel <= 7) ? 8'h03 : 8'($urandom_range(4, 255));
      d   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
      run_instr(mk_instr(op), d, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [63:0] ins2;
    ins2 = mk_instr(8'h01);
    ifc.instr       = mk_instr(8'h01);
    ifc.instr_valid = 1'b1;
    @(posedge clk); #1;
    ifc.instr = ins2;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    n_cmp++; if ({ifc.feature_fetch_enable, ifc.weight_fetch_enable, ifc.scaler_fetch_enable, ifc.cmd_done, ifc.busy, ifc.err_illegal, ifc.err_timeout, ifc.instr_ready} !== 8'b0000_0001) begin
      n_fail++; $display("FAIL rst_wait_ctrl: got %b want 00000001", {ifc.feature_fetch_enable, ifc.weight_fetch_enable, ifc.scaler_fetch_enable, ifc.cmd_done, ifc.busy, ifc.err_illegal, ifc.err_timeout, ifc.instr_ready}); end
    n_cmp++; if ({ifc.fetch_type, ifc.src_addr, ifc.mem_sel, ifc.instr_count} !== 48'h0) begin
      n_fail++; $display("FAIL rst_wait_data: got %h want 0", {ifc.fetch_type, ifc.src_addr, ifc.mem_sel, ifc.instr_count}); end
    @(posedge clk); #1;
    n_cmp++; if (ifc.cmd_done !== 1'b0) begin n_fail++; $display("FAIL rst_wait_no_done: got %b want 0", ifc.cmd_done); end
    rst     = 1'b1;
    m_count = '0;
    m_ill   = 1'b0;
    m_to    = 1'b0;
    run_instr(ins2, 5, 1'b0);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_feature();
    test_weight();
    test_scaler();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
